ysyx_25040129_wb_scoreboard: RTL
================================

# ysyx_25040129_wb_scoreboard

In-order register scoreboard that schedules instruction issue against pending write-backs. Sits between IDU issue and WBU retire. Tracks in-flight GPR and CSR writes and withholds `issue_ready` on read-after-write hazards. When the only pending writer of a source register is retiring this cycle, it selects the WBU forward path instead of stalling.

## Interface
Parameters:
- `REGS_DIG`, default 4: GPR index width (16 registers, RV32E).
- `CNT_W`, default 2: per-register pending-write counter width; max in-flight writes per register = 2^CNT_W−1.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `issue_valid` in 1: IDU presents an instruction.
- `issue_ready` out 1: combinational; the instruction may issue this cycle.
- `issue_rs1`, `issue_rs2` in REGS_DIG: source indices.
- `issue_use_rs1`, `issue_use_rs2` in 1: the source is actually read.
- `issue_rd` in REGS_DIG: destination index.
- `issue_rd_we` in 1: the instruction writes a GPR.
- `issue_csr_re`, `issue_csr_we` in 1: the instruction reads / writes a CSR.
- `retire_valid` in 1: WBU valid/ready handshake completes (one instruction retires).
- `retire_rd` in REGS_DIG, `retire_reg_we` in 1, `retire_csr_we` in 1: the retiring instruction's write info.
- `flush` in 1: kills all in-flight instructions.
- `fwd_rs1`, `fwd_rs2` out 1: combinational; the source must take WBU forward data.
- `pending_any` out 1: registered; some GPR or CSR write is pending.
- `stall_cycles` out 32: registered count of cycles with `issue_valid & ~issue_ready`.

## Operation
- State:
  - `cnt[1..2^REGS_DIG−1]`: CNT_W bits each. x0 is never tracked; reads of x0 are never hazards; writes to x0 never count.
  - `csr_cnt`: CNT_W bits.
- Events:
  - `issue_fire = issue_valid & issue_ready`.
  - `ret = retire_valid`.
  - `ret_hit(r) = ret & retire_reg_we & retire_rd==r & r!=0`.
- Source hazard for source s (used, index r != 0):
  - No hazard if `cnt[r]==0`.
  - Forwardable if `cnt[r]==1 & ret_hit(r)`. Assert `fwd_s`; this is not a stall.
  - Otherwise stall.
  - `fwd_s` is 0 whenever the source is unused or r==0.
- Destination limits: stall if `issue_rd_we & issue_rd!=0 & cnt[rd]==max & ~ret_hit(rd)`.
- CSR rules:
  - Stall if `issue_csr_re & csr_cnt!=0`. There is no CSR forwarding.
  - Stall if `issue_csr_we & csr_cnt==max & ~(ret & retire_csr_we)`.
- `issue_ready = ~any stall & ~flush`. It is independent of `issue_valid`.
- Counter update per register r:
  - +1 on `issue_fire & issue_rd_we & issue_rd==r`.
  - −1 on `ret_hit(r)`.
  - Both in the same cycle: no change.
- `csr_cnt` updates the same way, from `issue_csr_we` and `retire_csr_we`.
- Retire with a counter already 0 is a protocol error: the counter holds at 0 (no underflow).
- `flush`: all counters clear to 0 next edge. Same-cycle issue and retire are ignored.
- `stall_cycles`: increments when `issue_valid & ~issue_ready & ~flush`, wraps at 2^32−1 → 0, and is not cleared by flush.
- `pending_any`: registered OR of all next-state counters != 0.

## Timing
- Reset values:
  - All counters 0.
  - `pending_any` 0, `stall_cycles` 0.
  - `issue_ready` 1 and `fwd_*` 0 (combinational from reset state).
- Counter updates are visible one cycle after the edge.
- Back-to-back dependent issue:
  - If the producer retires in cycle N, a consumer presented in cycle N issues in N with forwarding.
  - Presented at N+1, the consumer issues without forwarding.
- Reset asserted mid-operation clears everything immediately. No issue fires while reset is high.
- Latency issue→counter = 1 cycle; retire→counter = 1 cycle.

## Test plan
- Reset, then issue `rd=5` (we). Next cycle issue `rs1=5`: expect `issue_ready=0` and `stall_cycles` increments. Retire rd=5 in that cycle: expect `issue_ready=1`, `fwd_rs1=1`, `cnt[5]=0` after the edge.
- Issue three writes to x3 (cnt=3). A 4th write to x3 is stalled. Retire x3 in the same cycle: the 4th issues and cnt stays 3.
- Issue `rd=0`, then read x0: no stall, `fwd=0`, `pending_any=0`.
- Two pending writes to x7, retire one while reading x7: stall (cnt=2, no forward). After the second retire: issue.
- CSR write issued, then CSR read: stalled until `retire_csr_we`; no forward. Then `pending_any` → 0.
- Five pending writes across regs, assert `flush`: next cycle all counters 0 and `pending_any=0`; `stall_cycles` retained. Async `reset` mid-stall zeroes `stall_cycles` without a clock edge.

Source files
------------

// File: rtl/ysyx_25040129_wb_scoreboard.sv
// In-order GPR/CSR write-back scoreboard: counts in-flight writes, holds off
// issue on read-after-write hazards and selects the WBU forward path when legal.
module ysyx_25040129_wb_scoreboard #(
    parameter int REGS_DIG = 4,
    parameter int CNT_W    = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [REGS_DIG-1:0] issue_rs1,
    input  logic [REGS_DIG-1:0] issue_rs2,
    input  logic                issue_use_rs1,
    input  logic                issue_use_rs2,
    input  logic [REGS_DIG-1:0] issue_rd,
    input  logic                issue_rd_we,
    input  logic                issue_csr_re,
    input  logic                issue_csr_we,
    input  logic                retire_valid,
    input  logic [REGS_DIG-1:0] retire_rd,
    input  logic                retire_reg_we,
    input  logic                retire_csr_we,
    input  logic                flush,
    output logic                fwd_rs1,
    output logic                fwd_rs2,
    output logic                pending_any,
    output logic [31:0]         stall_cycles
);

    localparam int                NREG     = 1 << REGS_DIG;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [CNT_W-1:0] csr_cnt_q;
    logic [CNT_W-1:0] csr_cnt_d;
    logic             pending_any_q;
    logic             pending_any_d;
    logic [31:0]      stall_cycles_q;
    logic [31:0]      stall_cycles_d;

    logic [NREG-1:0]  ret_hit_s;
    logic [NREG-1:0]  wr_hit_s;
    logic [1:0]       src1_s;
    logic [1:0]       src2_s;
    logic             rd_stall_s;
    logic             csr_stall_s;
    logic             csr_ret_s;
    logic             issue_fire_s;

    // Returns {stall, fwd} for one source operand; a single pending writer
    // that retires this very cycle can be bypassed instead of waited on.
    function automatic logic [1:0] src_check(input logic             use_src,
                                             input logic [REGS_DIG-1:0] idx,
                                             input logic [CNT_W-1:0] cnt,
                                             input logic             hit);
        logic used;
        logic fwd;
        logic stall;
        used  = use_src & (idx != REGS_DIG'(0));
        fwd   = used & (cnt == CNT_ONE) & hit;
        stall = used & (cnt != CNT_ZERO) & ~fwd;
        return {stall, fwd};
    endfunction

    // Saturating-at-zero up/down step of one pending-write counter.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                  input logic             inc,
                                                  input logic             dec,
                                                  input logic             clr);
        logic [CNT_W-1:0] nxt;
        if (clr) begin
            nxt = CNT_ZERO;
        end else if (inc & ~dec) begin
            nxt = cnt + CNT_ONE;
        end else if (dec & ~inc & (cnt != CNT_ZERO)) begin
            nxt = cnt - CNT_ONE;
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

    // Per-register retire and issue-write decode; x0 never matches.
    always_comb begin
        ret_hit_s = '0;
        wr_hit_s  = '0;
        for (int r = 1; r < NREG; r++) begin
            ret_hit_s[r] = retire_valid & retire_reg_we & (retire_rd == REGS_DIG'(r));
            wr_hit_s[r]  = issue_fire_s & issue_rd_we & (issue_rd == REGS_DIG'(r));
        end
    end

    // Hazard evaluation and the issue handshake.
    always_comb begin
        src1_s      = src_check(issue_use_rs1, issue_rs1, cnt_q[issue_rs1], ret_hit_s[issue_rs1]);
        src2_s      = src_check(issue_use_rs2, issue_rs2, cnt_q[issue_rs2], ret_hit_s[issue_rs2]);
        rd_stall_s  = issue_rd_we & (issue_rd != REGS_DIG'(0)) &
                      (cnt_q[issue_rd] == CNT_MAX) & ~ret_hit_s[issue_rd];
        csr_ret_s   = retire_valid & retire_csr_we;
        csr_stall_s = (issue_csr_re & (csr_cnt_q != CNT_ZERO)) |
                      (issue_csr_we & (csr_cnt_q == CNT_MAX) & ~csr_ret_s);
        issue_ready  = ~(src1_s[1] | src2_s[1] | rd_stall_s | csr_stall_s) & ~flush;
        issue_fire_s = issue_valid & issue_ready;
        fwd_rs1      = src1_s[0];
        fwd_rs2      = src2_s[0];
    end

    // Next-state counters, pending summary and stall statistics.
    always_comb begin
        pending_any_d = 1'b0;
        cnt_d[0]      = CNT_ZERO;
        for (int r = 1; r < NREG; r++) begin
            cnt_d[r]      = cnt_step(cnt_q[r], wr_hit_s[r], ret_hit_s[r], flush);
            pending_any_d = pending_any_d | (cnt_d[r] != CNT_ZERO);
        end
        csr_cnt_d     = cnt_step(csr_cnt_q, issue_fire_s & issue_csr_we, csr_ret_s, flush);
        pending_any_d = pending_any_d | (csr_cnt_d != CNT_ZERO);
        if (issue_valid & ~issue_ready & ~flush) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // State registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= CNT_ZERO;
            end
            csr_cnt_q      <= CNT_ZERO;
            pending_any_q  <= 1'b0;
            stall_cycles_q <= 32'd0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            csr_cnt_q      <= csr_cnt_d;
            pending_any_q  <= pending_any_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign pending_any  = pending_any_q;
    assign stall_cycles = stall_cycles_q;

endmodule
